// File: rtl/ov7670_capture_ctrl.sv
// ov7670_capture_ctrl: write-side sequencer for the camera frame buffer.
// Takes the OV7670 RGB444 byte stream (two bytes per pixel), builds 12-bit
// pixels, drives the buffer write port and tracks frame boundaries.
// Everything runs on wr_clk, the camera pixel clock.
// Optional feature: define CAPTURE_FRAME_CNT_EN to get the frame_cnt port
// and its 16-bit completed-frame counter.
module ov7670_capture_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       pix_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              short_frame
`ifdef CAPTURE_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    // Pixel count is one bit wider than the address so it can hold the full
    // frame size even when the frame exactly fills the address space.
    localparam logic [ADDR_W:0]   TOTAL_C     = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic              start_r;
    logic              cont_r;
    logic              vs_r;
    logic              vs_q_r;
    logic              href_r;
    logic [7:0]        data_r;

    logic              phase_r;
    logic [3:0]        red_r;
    logic [ADDR_W:0]   pix_cnt_r;
    logic [ADDR_W:0]   pix_cnt_nxt_s;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [11:0]       pix_data_r;
    logic              busy_r;
    logic              frame_done_r;
    logic              overflow_r;
    logic              short_r;

    logic              vs_fall_s;
    logic              vs_rise_s;
    logic              arm_go_s;
    logic              frame_end_s;
    logic              pix_wr_s;
    logic              ovf_hit_s;

    // Register every camera/control input once before use.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            start_r <= 1'b0;
            cont_r  <= 1'b0;
            vs_r    <= 1'b0;
            vs_q_r  <= 1'b0;
            href_r  <= 1'b0;
            data_r  <= 8'h00;
        end else begin
            start_r <= start;
            cont_r  <= continuous;
            vs_r    <= cam_vsync;
            vs_q_r  <= vs_r;
            href_r  <= cam_href;
            data_r  <= cam_data;
        end
    end

    assign vs_fall_s   = vs_q_r & ~vs_r;
    assign vs_rise_s   = ~vs_q_r & vs_r;
    assign arm_go_s    = (state_r == ARM) & vs_fall_s;
    assign frame_end_s = (state_r == ACTIVE) & vs_rise_s;

    // Decide whether the current byte completes a pixel that may be written,
    // or one that overruns the frame size.
    always_comb begin
        pix_wr_s  = 1'b0;
        ovf_hit_s = 1'b0;
        if ((state_r == ACTIVE) && href_r && phase_r) begin
            if (pix_cnt_r < TOTAL_C) begin
                pix_wr_s = 1'b1;
            end else begin
                ovf_hit_s = 1'b1;
            end
        end else begin
            pix_wr_s  = 1'b0;
            ovf_hit_s = 1'b0;
        end
        pix_cnt_nxt_s = pix_cnt_r + {{ADDR_W{1'b0}}, pix_wr_s};
    end

    // Capture sequencer state register.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture sequencer next-state logic; capture only begins on a VSYNC fall.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_r) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM: begin
                if (vs_fall_s) begin
                    state_nxt_s = ACTIVE;
                end else begin
                    state_nxt_s = ARM;
                end
            end
            ACTIVE: begin
                if (vs_rise_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            DONE: begin
                if (cont_r) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Byte phase and red-nibble holding register; phase resyncs on every HREF gap.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            phase_r <= 1'b0;
            red_r   <= 4'h0;
        end else if (arm_go_s) begin
            phase_r <= 1'b0;
        end else if ((state_r == ACTIVE) && href_r) begin
            phase_r <= ~phase_r;
            if (!phase_r) begin
                red_r <= data_r[3:0];
            end
        end else begin
            phase_r <= 1'b0;
        end
    end

    // Pixel counter and registered write port; addresses saturate, never wrap.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            pix_cnt_r  <= '0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            pix_data_r <= 12'h000;
        end else begin
            wr_en_r <= 1'b0;
            if (arm_go_s) begin
                pix_cnt_r <= '0;
                wr_addr_r <= '0;
            end else if (pix_wr_s) begin
                wr_en_r    <= 1'b1;
                wr_addr_r  <= pix_cnt_r[ADDR_W-1:0];
                pix_data_r <= {red_r, data_r};
                pix_cnt_r  <= pix_cnt_nxt_s;
            end else if (ovf_hit_s) begin
                wr_addr_r <= LAST_ADDR_C;
            end
        end
    end

    // Status: busy, frame-done pulse and the sticky overflow/short-frame flags.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
            short_r      <= 1'b0;
        end else begin
            busy_r       <= (state_nxt_s != IDLE);
            frame_done_r <= frame_end_s;
            if (arm_go_s) begin
                overflow_r <= 1'b0;
                short_r    <= 1'b0;
            end else begin
                if (ovf_hit_s) begin
                    overflow_r <= 1'b1;
                end
                // Count includes a pixel written on the same cycle as the VSYNC rise.
                if (frame_end_s && (pix_cnt_nxt_s < TOTAL_C)) begin
                    short_r <= 1'b1;
                end
            end
        end
    end

`ifdef CAPTURE_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame counter; wraps naturally and clears only on reset.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 16'h0000;
        end else if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign pix_data    = pix_data_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign overflow    = overflow_r;
    assign short_frame = short_r;

endmodule
